// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared constants and types for the data-island packet assembler.
package hdmi_pkg;
   localparam logic [7:0] BCH_POLY         = 8'h83;
   localparam int         PACKET_PIXELS    = 32;
   localparam int         HEADER_DATA_BITS = 24;
   localparam int         SUB_DATA_BITS    = 56;
   typedef logic [3:0][SUB_DATA_BITS-1:0] sub_array_t;
endpackage

// File: rtl/bch_ecc_step.sv
// bch_ecc_step: one LSB-first BCH ECC shift step.
module bch_ecc_step
   import hdmi_pkg::*;
(
   input  logic [7:0] ecc,
   input  logic       d,
   output logic [7:0] ecc_next
);
   assign ecc_next = (ecc >> 1) ^ ((ecc[0] ^ d) ? BCH_POLY : 8'h00);
endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: serialises header/subpackets with running BCH ECC into 9-bit pixel payloads.
module packet_assembler
   import hdmi_pkg::*;
(
   input  logic                        clk_pixel,
   input  logic                        reset,
   input  logic                        data_island_period,
   input  logic [HEADER_DATA_BITS-1:0] header,
   input  sub_array_t                  sub,
   output logic [8:0]                  packet_data,
   output logic [4:0]                  counter,
   output logic                        packet_enable
);
   localparam logic [4:0] LAST    = 5'(PACKET_PIXELS - 1);
   localparam logic [4:0] HDR_END = 5'(HEADER_DATA_BITS);
   localparam logic [4:0] SUB_END = 5'(SUB_DATA_BITS / 2);
   logic [4:0]      counter_q, counter_d;
   logic [7:0]      hdr_ecc_q, hdr_ecc_d, hdr_step;
   logic [3:0][7:0] sub_ecc_q, sub_ecc_d;
   logic [7:0]      sub_mid [4];
   logic [7:0]      sub_step [4];
   logic [3:0]      sub_even, sub_odd;
   logic            active, clear, in_hdr, in_sub;
   assign active = data_island_period & ~reset;
   assign in_hdr = counter_q < HDR_END;
   assign in_sub = counter_q < SUB_END;
   bch_ecc_step u_hdr (.ecc(hdr_ecc_q), .d(header[counter_q]), .ecc_next(hdr_step));
   for (genvar i = 0; i < 4; i++) begin : g_sub
      bch_ecc_step u_even (.ecc(sub_ecc_q[i]), .d(sub[i][{counter_q, 1'b0}]), .ecc_next(sub_mid[i]));
      bch_ecc_step u_odd  (.ecc(sub_mid[i]),   .d(sub[i][{counter_q, 1'b1}]), .ecc_next(sub_step[i]));
      // past the payload the ECC byte is sent two bits per pixel
      assign sub_even[i] = in_sub ? sub[i][{counter_q, 1'b0}] : sub_ecc_q[i][{counter_q[1:0], 1'b0}];
      assign sub_odd[i]  = in_sub ? sub[i][{counter_q, 1'b1}] : sub_ecc_q[i][{counter_q[1:0], 1'b1}];
   end
   always_comb begin
      clear     = ~data_island_period | (counter_q == LAST);
      counter_d = data_island_period ? counter_q + 5'd1 : 5'd0;
      hdr_ecc_d = clear ? 8'h00 : in_hdr ? hdr_step : hdr_ecc_q;
      for (int k = 0; k < 4; k++)
         sub_ecc_d[k] = clear ? 8'h00 : in_sub ? sub_step[k] : sub_ecc_q[k];
   end
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         counter_q <= '0;
         hdr_ecc_q <= '0;
         sub_ecc_q <= '0;
      end else begin
         counter_q <= counter_d;
         hdr_ecc_q <= hdr_ecc_d;
         sub_ecc_q <= sub_ecc_d;
      end
   end
   assign counter       = counter_q;
   assign packet_enable = active & (counter_q == LAST);
   assign packet_data   = active ? {sub_odd, sub_even, in_hdr ? header[counter_q] : hdr_ecc_q[counter_q[2:0]]} : 9'd0;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed and random checks of packet_assembler against a packet-level model.
module tb_packet_assembler;
   import hdmi_pkg::*;
   logic        clk_pixel = 0;
   logic        reset, dip;
   logic [23:0] header;
   sub_array_t  sub;
   logic [8:0]  packet_data;
   logic [4:0]  counter;
   logic        packet_enable;
   int          vectors = 0, errors = 0, m = 0, ens;
   logic        checking = 0;
   logic [8:0]  rec [32];
   logic [4:0]  cnt_rec [32];
   packet_assembler dut (
      .clk_pixel(clk_pixel), .reset(reset), .data_island_period(dip), .header(header),
      .sub(sub), .packet_data(packet_data), .counter(counter), .packet_enable(packet_enable)
   );
   always #5 clk_pixel = ~clk_pixel;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   function automatic logic [7:0] ecc_of(input logic [55:0] v, input int n);
      logic [7:0] e;
      logic fb;
      e = 0;
      for (int k = 0; k < n; k++) begin
         fb = e[0] ^ v[k];
         e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
      end
      return e;
   endfunction
   // whole-packet view: pixel c carries payload bits then the ECC over the full payload
   function automatic logic [8:0] exp_data(input int c);
      logic [8:0] r;
      logic [7:0] he, se;
      r  = 0;
      he = ecc_of({32'd0, header}, 24);
      r[0] = c < 24 ? header[c] : he[c-24];
      for (int i = 0; i < 4; i++) begin
         se       = ecc_of(sub[i], 56);
         r[1 + i] = c < 28 ? sub[i][2*c]     : se[2*(c-28)];
         r[5 + i] = c < 28 ? sub[i][2*c + 1] : se[2*(c-28) + 1];
      end
      return r;
   endfunction
   always @(posedge clk_pixel) m <= reset ? 0 : dip ? (m + 1) % 32 : 0;
   always @(negedge clk_pixel) if (checking) begin
      check("counter", 32'(counter), 32'(m));
      check("packet_enable", 32'(packet_enable), 32'(!reset && dip && m == 31));
      check("packet_data", 32'(packet_data), (!reset && dip) ? 32'(exp_data(m)) : 32'd0);
   end
   task automatic run_pkt(input logic [23:0] h, input sub_array_t s, input int n);
      header = h;
      sub    = s;
      dip    = 1;
      ens    = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk_pixel);
         rec[c]     = packet_data;
         cnt_rec[c] = counter;
         ens       += int'(packet_enable);
         @(posedge clk_pixel);
         #1;
      end
   endtask
   function automatic logic [31:0] bit0_vec();
      logic [31:0] v;
      for (int c = 0; c < 32; c++) v[c] = rec[c][0];
      return v;
   endfunction
   function automatic logic [8:0] or_all();
      logic [8:0] v;
      v = 0;
      for (int c = 0; c < 32; c++) v |= rec[c];
      return v;
   endfunction
   sub_array_t s0, s1;
   logic [7:0] e;
   initial begin
      reset = 1; dip = 0; header = 0; sub = '0;
      s0 = '0;
      s1 = '0;
      s1[0] = 56'h1;
      check("model_ecc_hdr1", 32'(ecc_of(56'h1, 24)), 32'h4A);
      check("model_ecc_zero", 32'(ecc_of(56'h0, 56)), 32'h0);
      @(posedge clk_pixel); #1;
      checking = 1;
      @(negedge clk_pixel);
      check("reset_counter", 32'(counter), 0);
      check("reset_data", 32'(packet_data), 0);
      check("reset_enable", 32'(packet_enable), 0);
      @(posedge clk_pixel); #1;
      reset = 0;
      @(posedge clk_pixel); #1;
      run_pkt(24'h0, s0, 32);
      check("null_data", 32'(or_all()), 0);
      check("null_enable_count", 32'(ens), 1);
      check("null_enable_at_31", 32'(rec[31] == 0 && cnt_rec[31] == 31), 1);
      run_pkt(24'h1, s0, 32);
      check("hdr1_bit0", bit0_vec(), 32'h4A000001);
      run_pkt(24'h0, s0, 32);
      check("b2b_null_data", 32'(or_all()), 0);
      run_pkt(24'h0, s1, 32);
      check("sub0_first_bit", 32'(rec[0][1]), 1);
      e = 0;
      for (int k = 0; k < 4; k++) begin
         e[2*k]     = rec[28 + k][1];
         e[2*k + 1] = rec[28 + k][5];
      end
      check("sub0_ecc", 32'(e), 32'(ecc_of(56'h1, 56)));
      e = 0;
      for (int c = 0; c < 32; c++) e |= {2'b0, rec[c][8:6], rec[c][4:2]};
      check("sub123_zero", 32'(e), 0);
      run_pkt(24'h1, s0, 13);
      dip = 0;
      repeat (4) begin @(posedge clk_pixel); #1; end
      run_pkt(24'h1, s0, 32);
      check("drop_restart_cnt", 32'(cnt_rec[0]), 0);
      check("drop_hdr1_bit0", bit0_vec(), 32'h4A000001);
      run_pkt(24'h1, s0, 20);
      reset = 1;
      @(negedge clk_pixel);
      check("rst20_enable", 32'(packet_enable), 0);
      @(posedge clk_pixel); #1;
      reset = 0;
      run_pkt(24'h1, s0, 32);
      check("rst20_restart_cnt", 32'(cnt_rec[0]), 0);
      check("rst20_hdr1_bit0", bit0_vec(), 32'h4A000001);
      for (int n = 0; n < 4000; n++) begin
         if (m == 0 && $urandom_range(1, 0) == 1) begin
            header = 24'($urandom);
            for (int i = 0; i < 4; i++) sub[i] = 56'({$urandom, $urandom});
         end
         dip   = ($urandom % 50) != 0;
         reset = ($urandom % 300) == 0;
         @(posedge clk_pixel); #1;
      end
      reset = 0;
      dip   = 0;
      @(posedge clk_pixel); #1;
      @(negedge clk_pixel);
      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 clk_pixel  input  1  pixel clock; all state on rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 data_island_period  input  1  high while data-island packet pixels are sent.
REQ-004 header  input  24  packet header HB0..HB2 (HB0 = bits 7:0); stable for all 32 cycles of a packet.
REQ-005 sub  input  4x56  subpackets 0..3, 7 bytes each, byte 0 = bits 7:0; stable for all 32 cycles of a packet.
REQ-006 packet_data  output  9  per-pixel payload: bit 0 = header/ECC bit; bits 4:1 = even bits of sub3..sub0; bits 8:5 = odd bits of sub3..sub0, sub0 in the lowest position of each nibble.
REQ-007 counter  output  5  pixel index within the current packet, 0..31.
REQ-008 packet_enable  output  1  one-cycle pulse requesting the next packet from the upstream picker.

Function
REQ-009 counter SHALL increment by 1 on each cycle with data_island_period high, and wrap 31 -> 0.
REQ-010 counter SHALL clear to 0 on any cycle with data_island_period low; a partial packet is abandoned.
REQ-011 packet_enable SHALL equal data_island_period AND (counter == 31), combinationally.
- The upstream picker latches a new header/sub on that edge.
- The new packet is valid from counter == 0 onward.
REQ-012 ECC step SHALL be: fb = ecc[0] XOR d; ecc_next = (ecc >> 1) XOR (fb ? 8'h83 : 8'h00); data is consumed LSB first.
REQ-013 One 8-bit header ECC register and four 8-bit subpacket ECC registers SHALL be kept.
REQ-014 Counter 0..23: packet_data[0] = header[counter]; header ECC SHALL step once per cycle with that bit.
REQ-015 Counter 24..31: packet_data[0] = header_ecc[counter-24]; header ECC SHALL hold.
REQ-016 Counter 0..27, per subpacket i: packet_data even bit = sub[i][2*counter], odd bit = sub[i][2*counter+1].
REQ-017 Counter 0..27: each sub ECC SHALL step twice per cycle, even bit first then odd bit.
REQ-018 Counter 28..31, per subpacket i: even bit = sub_ecc[i][2*(counter-28)], odd bit = sub_ecc[i][2*(counter-28)+1]; sub ECCs SHALL hold.
REQ-019 packet_data SHALL be combinational from counter, header, sub and the ECC registers; there is zero latency from counter to data.
REQ-020 All ECC registers SHALL load 0 on the edge where counter wraps 31 -> 0, so back-to-back packets start with clean ECC.
REQ-021 All ECC registers SHALL load 0 while data_island_period is low.
REQ-022 If data_island_period is low, packet_data SHALL be 9'd0.

Reset
REQ-023 On reset: counter = 0, all ECC registers = 0, packet_enable = 0, packet_data = 0.
REQ-024 Reset SHALL take priority over data_island_period.
REQ-025 Reset mid-packet SHALL abandon the packet; the first cycle after release with data_island_period high is counter 0.

Structure
REQ-026 Package hdmi_pkg SHALL hold:
- BCH_POLY = 8'h83
- PACKET_PIXELS = 32
- HEADER_DATA_BITS = 24
- SUB_DATA_BITS = 56
- a typedef for the 4x56 subpacket array.
REQ-027 A single combinational sub-module bch_ecc_step SHALL be used.
- Inputs: ecc(8), d(1). Output: ecc_next(8).
- Instantiated once for the header and twice in series per subpacket (9 instances).

Verification
REQ-028 Null packet: header 0, subs 0, data_island_period high for 32 cycles -> packet_data = 0 every cycle; packet_enable pulses only at counter 31.
REQ-029 header = 24'h000001, subs 0 -> packet_data[0] = 1 at counter 0, 0 at counters 1..23, and LSB-first 0x4A (0,1,0,1,0,0,1,0) at counters 24..31.
REQ-030 sub[0] = 56'h1, others 0 -> packet_data[1] = 1 at counter 0; counters 28..31 carry sub0 ECC matching the software model of REQ-012 over 56 bits; bits for sub1..sub3 stay 0.
REQ-031 Back-to-back packets: run the REQ-029 packet, then the null packet with no gap -> the second packet has packet_data = 0 at all 32 counters (ECC cleared at wrap).
REQ-032 data_island_period drops at counter 13 and reasserts 4 cycles later -> counter restarts at 0 and a full 32-cycle REQ-029 sequence is reproduced exactly.
REQ-033 reset asserted at counter 20 for 1 cycle with data_island_period high -> counter = 0 and ECC = 0 next cycle, packet_enable stays low, and the next packet's data is correct.
